// File: rtl/radix_4_qds_otfc_pkg.sv
// Shared quotient-digit encoding and converter state codes for the radix-4 SRT divider.
package radix_4_qds_otfc_pkg;

  // One-hot digit bit positions, shared with the sign coder.
  localparam int unsigned QUOT_NEG_2 = 0;
  localparam int unsigned QUOT_NEG_1 = 1;
  localparam int unsigned QUOT_ZERO  = 2;
  localparam int unsigned QUOT_POS_1 = 3;
  localparam int unsigned QUOT_POS_2 = 4;

  typedef logic [4:0] quot_dig_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/radix_4_otfc_step.sv
// One on-the-fly conversion step: appends a radix-4 digit to Q and QM (QM = Q - 1).
module radix_4_otfc_step
  import radix_4_qds_otfc_pkg::*;
#(
  parameter int unsigned QUOT_W = 32
) (
  input  logic [QUOT_W-1:0] q_i,
  input  logic [QUOT_W-1:0] qm_i,
  input  logic [4:0]        dig_i,
  output logic [QUOT_W-1:0] q_o,
  output logic [QUOT_W-1:0] qm_o,
  output logic              illegal_o
);

  logic [QUOT_W-3:0] q_lo;
  logic [QUOT_W-3:0] qm_lo;

  assign q_lo  = q_i[QUOT_W-3:0];
  assign qm_lo = qm_i[QUOT_W-3:0];

  always_comb begin
    q_o       = {q_lo, 2'b00};
    qm_o      = {qm_lo, 2'b11};
    illegal_o = 1'b0;
    case (dig_i)
      5'b1 << QUOT_POS_2: begin
        q_o  = {q_lo, 2'b10};
        qm_o = {q_lo, 2'b01};
      end
      5'b1 << QUOT_POS_1: begin
        q_o  = {q_lo, 2'b01};
        qm_o = {q_lo, 2'b00};
      end
      5'b1 << QUOT_ZERO: begin
        q_o  = {q_lo, 2'b00};
        qm_o = {qm_lo, 2'b11};
      end
      5'b1 << QUOT_NEG_1: begin
        q_o  = {qm_lo, 2'b11};
        qm_o = {qm_lo, 2'b10};
      end
      5'b1 << QUOT_NEG_2: begin
        q_o  = {qm_lo, 2'b10};
        qm_o = {qm_lo, 2'b01};
      end
      // Non-one-hot digits fall back to the zero-digit update.
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/radix_4_qds_otfc.sv
// On-the-fly quotient converter: sequences ITER_N radix-4 digits into Q and QM registers.
module radix_4_qds_otfc
  import radix_4_qds_otfc_pkg::*;
#(
  parameter int unsigned QUOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              quot_dig_vld_i,
  input  logic [4:0]        quot_dig_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [QUOT_W-1:0] quot_o,
  output logic [QUOT_W-1:0] quot_m1_o
);

  localparam int unsigned ITER_N = QUOT_W / 2;
  localparam int unsigned CntW   = $clog2(ITER_N + 1);

  logic [1:0]        state_q, state_d;
  logic [QUOT_W-1:0] q_q, q_d, qm_q, qm_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [QUOT_W-1:0] step_q, step_qm;
  logic              step_illegal;

  radix_4_otfc_step #(
    .QUOT_W (QUOT_W)
  ) u_step (
    .q_i       (q_q),
    .qm_i      (qm_q),
    .dig_i     (quot_dig_i),
    .q_o       (step_q),
    .qm_o      (step_qm),
    .illegal_o (step_illegal)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = StIdle;
      q_d     = '0;
      qm_d    = '1;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d = StRun;
      q_d     = '0;
      qm_d    = '1;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (quot_dig_vld_i) begin
            q_d   = step_q;
            qm_d  = step_qm;
            cnt_d = cnt_q + 1'b1;
            if (step_illegal) err_d = 1'b1;
            if (cnt_q == CntW'(ITER_N - 1)) state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign err_o     = err_q;
  assign quot_o    = q_q;
  assign quot_m1_o = qm_q;

endmodule

// File: tb/tb_radix_4_qds_otfc.sv
// Directed self-checking bench for the radix-4 on-the-fly quotient converter.
module tb_radix_4_qds_otfc;

  localparam logic [4:0] D_P2 = 5'b10000;
  localparam logic [4:0] D_P1 = 5'b01000;
  localparam logic [4:0] D_Z  = 5'b00100;
  localparam logic [4:0] D_N1 = 5'b00010;
  localparam logic [4:0] D_N2 = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        quot_dig_vld_i = 1'b0;
  logic [4:0]  quot_dig_i = 5'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] quot_o, quot_m1_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  radix_4_qds_otfc #(
    .QUOT_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .flush_i        (flush_i),
    .quot_dig_vld_i (quot_dig_vld_i),
    .quot_dig_i     (quot_dig_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .quot_o         (quot_o),
    .quot_m1_o      (quot_m1_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    quot_dig_vld_i = 1'b1;
    quot_dig_i = D_N2;
    tick();
    start_i = 1'b0;
    quot_dig_vld_i = 1'b0;
  endtask

  task automatic feed(input logic [4:0] d);
    quot_dig_vld_i = 1'b1;
    quot_dig_i = d;
    tick();
    quot_dig_vld_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_tests++;
    if ({busy_o, done_o, err_o} !== 3'b000 || quot_o !== 32'h0 || quot_m1_o !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL reset: busy/done/err=%b q=%h qm=%h, want 000 00000000 ffffffff",
               {busy_o, done_o, err_o}, quot_o, quot_m1_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_plus1();
    int done_seen = 0;
    do_start();
    n_tests++;
    if (busy_o !== 1'b1 || quot_o !== 32'h0) begin
      n_fail++;
      $display("FAIL plus1_start: busy=%b q=%h, want 1 00000000", busy_o, quot_o);
    end
    for (int i = 0; i < 16; i++) begin
      feed(D_P1);
      if (done_o) done_seen++;
      if (i < 15 && busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL plus1_busy: digit %0d busy=%b, want 1", i, busy_o);
      end
    end
    n_tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || done_seen != 1) begin
      n_fail++;
      $display("FAIL plus1_done: done=%b busy=%b pulses=%0d, want 1 0 1", done_o, busy_o, done_seen);
    end
    n_tests++;
    if (quot_o !== 32'h55555555 || quot_m1_o !== 32'h55555554 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL plus1_value: q=%h qm=%h err=%b, want 55555555 55555554 0",
               quot_o, quot_m1_o, err_o);
    end
    feed(D_N2);
    tick();
    n_tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || quot_o !== 32'h55555555 ||
        quot_m1_o !== 32'h55555554) begin
      n_fail++;
      $display("FAIL plus1_idle_hold: done=%b busy=%b q=%h qm=%h, want 0 0 55555555 55555554",
               done_o, busy_o, quot_o, quot_m1_o);
    end
  endtask

  task automatic test_plus2_gaps();
    int gaps[16] = '{0, 3, 1, 2, 0, 0, 3, 1, 2, 2, 0, 1, 3, 0, 1, 2};
    int busy_drop = 0;
    do_start();
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        quot_dig_i = D_N2;
        tick();
        if (busy_o !== 1'b1) busy_drop++;
      end
      feed(D_P2);
      if (i < 15 && busy_o !== 1'b1) busy_drop++;
    end
    n_tests++;
    if (busy_drop != 0 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL plus2_busy: busy drops=%0d done=%b, want 0 1", busy_drop, done_o);
    end
    n_tests++;
    if (quot_o !== 32'hAAAAAAAA || quot_m1_o !== 32'hAAAAAAA9) begin
      n_fail++;
      $display("FAIL plus2_value: q=%h qm=%h, want aaaaaaaa aaaaaaa9", quot_o, quot_m1_o);
    end
    tick();
  endtask

  task automatic test_mixed();
    do_start();
    feed(D_P1);
    for (int i = 0; i < 14; i++) feed(D_Z);
    feed(D_N1);
    n_tests++;
    if (quot_o !== 32'h3FFFFFFF || quot_m1_o !== 32'h3FFFFFFE || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_value: q=%h qm=%h done=%b, want 3fffffff 3ffffffe 1",
               quot_o, quot_m1_o, done_o);
    end
    tick();
    do_start();
    feed(D_N2);
    n_tests++;
    if (quot_o !== 32'hFFFFFFFE || quot_m1_o !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL neg2_first: q=%h qm=%h, want fffffffe fffffffd", quot_o, quot_m1_o);
    end
    for (int i = 0; i < 15; i++) feed(D_Z);
    n_tests++;
    if (quot_o !== 32'h80000000 || quot_m1_o !== 32'h7FFFFFFF || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL neg2_value: q=%h qm=%h done=%b, want 80000000 7fffffff 1",
               quot_o, quot_m1_o, done_o);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_start();
    for (int i = 0; i < 16; i++) begin
      feed(i == 5 ? 5'b00011 : D_P1);
      if (i == 4 && err_o !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL illegal_early: err=%b before bad digit, want 0", err_o);
      end
    end
    n_tests++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || quot_o !== 32'h55455555 ||
        quot_m1_o !== 32'h55455554) begin
      n_fail++;
      $display("FAIL illegal_value: err=%b done=%b q=%h qm=%h, want 1 1 55455555 55455554",
               err_o, done_o, quot_o, quot_m1_o);
    end
    tick();
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sticky: err=%b in idle, want 1", err_o);
    end
    do_start();
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: err=%b after start, want 0", err_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_flush();
    do_start();
    for (int i = 0; i < 7; i++) feed(i == 2 ? 5'b00000 : D_P1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || quot_o !== 32'h0 ||
        quot_m1_o !== 32'hFFFFFFFF || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: busy=%b done=%b q=%h qm=%h err=%b, want 0 0 00000000 ffffffff 1",
               busy_o, done_o, quot_o, quot_m1_o, err_o);
    end
    for (int i = 0; i < 10; i++) feed(D_P1);
    n_tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || quot_o !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_ignore: done=%b busy=%b q=%h, want 0 0 00000000", done_o, busy_o, quot_o);
    end
    start_i = 1'b1;
    flush_i = 1'b1;
    tick();
    start_i = 1'b0;
    flush_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_beats_start: busy=%b err=%b, want 0 1", busy_o, err_o);
    end
  endtask

  task automatic test_restart();
    int done_seen = 0;
    do_start();
    for (int i = 0; i < 5; i++) feed(D_N1);
    do_start();
    n_tests++;
    if (busy_o !== 1'b1 || quot_o !== 32'h0 || quot_m1_o !== 32'hFFFFFFFF || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: busy=%b q=%h qm=%h done=%b, want 1 00000000 ffffffff 0",
               busy_o, quot_o, quot_m1_o, done_o);
    end
    for (int i = 0; i < 16; i++) begin
      feed(D_P1);
      if (done_o) done_seen++;
    end
    n_tests++;
    if (done_seen != 1 || quot_o !== 32'h55555555) begin
      n_fail++;
      $display("FAIL restart_value: pulses=%0d q=%h, want 1 55555555", done_seen, quot_o);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    do_start();
    for (int i = 0; i < 4; i++) feed(D_P2);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_o, done_o, err_o} !== 3'b000 || quot_o !== 32'h0 || quot_m1_o !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL rst_mid: busy/done/err=%b q=%h qm=%h, want 000 00000000 ffffffff",
               {busy_o, done_o, err_o}, quot_o, quot_m1_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_plus1();
    test_plus2_gaps();
    test_mixed();
    test_illegal();
    test_flush();
    test_restart();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/radix_4_qds_otfc.md
Name: radix_4_qds_otfc

Overview:
On-the-fly quotient converter for the radix-4 SRT divider.
- Consumes the one-hot redundant quotient digit that the radix-4 sign coder produces each iteration.
- Accumulates two non-redundant binary forms of the quotient: Q and QM, where QM = Q - 1.
- At completion the divider back-end selects Q or QM as the final quotient, depending on the remainder sign, with no carry-propagate add.

Parameters:
QUOT_W  32  quotient width in bits; must be even and >= 4
ITER_N  QUOT_W/2  localparam, number of radix-4 digits per division (not overridable)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
start_i  input  1  begin a new conversion; clears accumulators
flush_i  input  1  abort the current conversion and return to IDLE
quot_dig_vld_i  input  1  quot_dig_i is valid this cycle
quot_dig_i  input  5  one-hot digit; bit0=-2, bit1=-1, bit2=0, bit3=+1, bit4=+2
busy_o  output  1  conversion in progress
done_o  output  1  one-cycle pulse after the last digit is absorbed
err_o  output  1  sticky: a non-one-hot digit was accepted during this conversion
quot_o  output  QUOT_W  accumulated Q
quot_m1_o  output  QUOT_W  accumulated QM (= Q - 1 mod 2^QUOT_W)

Behaviour:
- Reset (async, rst=1):
  - State=IDLE.
  - quot_o=0, quot_m1_o=all-ones.
  - busy_o=0, done_o=0, err_o=0.
  - Iteration counter=0.
- States: IDLE, RUN, DONE.
- Start:
  - start_i=1 in any state (flush_i=0) at the clock edge → RUN, Q=0, QM=all-ones, counter=0, err_o=0.
  - A digit presented in the same cycle as start_i is ignored.
- RUN: each cycle with quot_dig_vld_i=1 absorbs one digit. Q and QM shift left by 2 with these updates:
  - +2: Q={Q,10}, QM={Q,01}
  - +1: Q={Q,01}, QM={Q,00}
  - 0: Q={Q,00}, QM={QM,11}
  - -1: Q={QM,11}, QM={QM,10}
  - -2: Q={QM,10}, QM={QM,01}
  - Upper bits shifted out are discarded (mod 2^QUOT_W).
- Illegal digit: a non-one-hot quot_dig_i (zero or more than one bit set) with valid=1 is absorbed as digit 0 and sets err_o. err_o stays set until the next start_i or rst.
- Gaps: quot_dig_vld_i=0 in RUN holds all state. Arbitrary gaps are legal.
- Counter: increments per absorbed digit. When the ITER_N-th digit is absorbed → DONE on that edge.
- DONE:
  - done_o=1 for exactly that one cycle.
  - The next cycle returns to IDLE with quot_o/quot_m1_o holding their final values.
  - Outputs hold in IDLE until the next start_i.
- busy_o: 1 in RUN only. Latency: done_o rises the cycle after the last valid digit edge.
- Digits outside RUN: quot_dig_vld_i in IDLE/DONE is ignored.
- flush_i:
  - Synchronous, highest priority; beats start_i in the same cycle.
  - → IDLE, busy_o=0, done_o=0, Q=0, QM=all-ones, counter=0. err_o is unchanged.
- Restart: start_i during RUN restarts the conversion, discarding partial results; no done_o is issued.
- Invariant after every update: quot_m1_o == quot_o - 1 mod 2^QUOT_W.

Decomposition:
- Shared package: digit index constants QUOT_NEG_2=0, QUOT_NEG_1=1, QUOT_ZERO=2, QUOT_POS_1=3, QUOT_POS_2=4; the 5-bit digit typedef; state enum {IDLE, RUN, DONE}. The sign coder and this block share these constants.
- One combinational sub-module, radix_4_otfc_step:
  - Inputs: Q, QM, digit.
  - Outputs: next Q, next QM, illegal flag.
  - Sequential control, counter and registers stay in the top module.

Test Plan:
- 16 digits of +1 (QUOT_W=32), valid every cycle → done_o pulses once, 17 cycles after start; quot_o=0x55555555, quot_m1_o=0x55555554, err_o=0.
- 16 digits of +2 with random valid gaps (0–3 idle cycles) → quot_o=0xAAAAAAAA, quot_m1_o=0xAAAAAAA9; busy_o high throughout.
- +1, then 14×0, then -1 → quot_o=0x3FFFFFFF, quot_m1_o=0x3FFFFFFE.
- First digit -2, rest 0 → quot_o=0x80000000 (mod 2^32 of -2·4^15), quot_m1_o=0x7FFFFFFF.
- Digit 5'b00011 at iteration 5, others +1 → err_o=1 and stays set through DONE; quot_o=0x55555555 with bits [21:20]=00 (i.e., 0x55455555).
- flush_i asserted after 7 digits → next cycle IDLE, busy_o=0, quot_o=0, quot_m1_o=0xFFFFFFFF, no done_o. start_i+flush_i together → flush wins. rst mid-RUN → all outputs at reset values immediately.
